// File: rtl/nios_system_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios_system_pio_pkg
// Shared definitions for the Nios II system PIO blocks: Avalon-MM word
// addresses of the input PIO register map and the edge-type encodings used
// by the input-capture PIO's EDGE_TYPE parameter.
// No ports (package).
// -----------------------------------------------------------------------------
package nios_system_pio_pkg;

  // Register map, word addresses on the 2-bit Avalon address bus.
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Edge-type encodings for the capture condition.
  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

endpackage : nios_system_pio_pkg

// File: rtl/nios_system_pio_edge_detect.sv
// -----------------------------------------------------------------------------
// nios_system_pio_edge_detect
// Input sampling and per-bit edge detection for the input-capture PIO.
// Optional two-flop synchronizer (macro NIOS_PIO_INPUT_SYNC_EN), then the
// s0/s1 sample pair, a 'primed' qualifier and the per-bit event vector.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   in_port    in   [WIDTH] external input bus
//   sample     out  [WIDTH] current sampled value (s0), shown as DATA
//   edge_event out  [WIDTH] one-cycle per-bit capture events
// -----------------------------------------------------------------------------
module nios_system_pio_edge_detect
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EDGE_TYPE = PIO_EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] edge_event
);

  logic [WIDTH-1:0] s0_d;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] raw_event;

`ifdef NIOS_PIO_INPUT_SYNC_EN
  // Two flops of synchronizer ahead of s0; s1 holds a genuine sample only
  // after the fourth post-reset edge.
  localparam int PRIME_DEPTH = 4;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  assign s0_d = sync2;
`else
  // s0 follows in_port directly; s1 holds a genuine sample after the
  // second post-reset edge.
  localparam int PRIME_DEPTH = 2;

  assign s0_d = in_port;
`endif

  // Ones shift in after reset release; 'primed' rises once s0 and s1 both
  // hold post-reset samples, so the reset-value -> first-sample step is
  // never reported as an edge.
  logic [PRIME_DEPTH-1:0] prime_sr;
  logic                   primed;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0       <= '0;
      s1       <= '0;
      prime_sr <= '0;
    end else begin
      s0       <= s0_d;
      s1       <= s0;
      prime_sr <= {prime_sr[PRIME_DEPTH-2:0], 1'b1};
    end
  end

  assign primed = prime_sr[PRIME_DEPTH-1];

  // NOTE: the combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    raw_event = '0;
    case (EDGE_TYPE)
      PIO_EDGE_RISE: raw_event = s0 & ~s1;
      PIO_EDGE_FALL: raw_event = ~s0 & s1;
      default:       raw_event = s0 ^ s1;
    endcase
  end

  assign sample     = s0;
  assign edge_event = primed ? raw_event : '0;

endmodule : nios_system_pio_edge_detect

// File: rtl/nios_system_pio_input_capture.sv
// -----------------------------------------------------------------------------
// nios_system_pio_input_capture
// Avalon-MM slave input PIO: exposes the sampled input bus, latches per-bit
// edge events into a sticky, write-1-to-clear capture register and drives a
// maskable level interrupt.
//
// Register map (word address): 0 DATA (RO), 1 reserved (reads 0),
//   2 IRQMASK (RW), 3 EDGECAP (read sticky bits, write 1 to clear).
// Optional feature: define NIOS_PIO_INPUT_SYNC_EN to insert a two-flop
//   input synchronizer (handled inside nios_system_pio_edge_detect).
//
// Ports:
//   clk        in   system clock, the only clock
//   reset      in   synchronous, active-high reset
//   address    in   [2] register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [32] write data, bits above WIDTH ignored
//   readdata   out  [32] read data, zero-extended above WIDTH (0 latency)
//   in_port    in   [WIDTH] external input bus
//   irq        out  level interrupt, |(EDGECAP & IRQMASK)
// -----------------------------------------------------------------------------
module nios_system_pio_input_capture
  import nios_system_pio_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               EDGE_TYPE      = PIO_EDGE_RISE,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clear;
  logic             wr_en;

  nios_system_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sample     (sample),
    .edge_event (edge_event)
  );

  assign wr_en     = chipselect && !write_n;
  assign cap_clear = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= IRQ_MASK_RESET;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == PIO_ADDR_IRQMASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // Clear is applied first and the event ORed in after, so a new event
      // on a bit being cleared in the same cycle keeps that bit set.
      edge_cap <= (edge_cap & ~cap_clear) | edge_event;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = sample;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

  // Write-data bits above the bus width have no destination.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

endmodule : nios_system_pio_input_capture

// File: tb/tb_nios_system_pio_input_capture.sv
// -----------------------------------------------------------------------------
// tb_nios_system_pio_input_capture
// Directed, scoreboard-checked bench for the input-capture PIO (default
// build, no input synchronizer). Three instances share the Avalon bus and
// differ in edge type: A rising (non-zero mask reset), B falling, C any.
// -----------------------------------------------------------------------------
module tb_nios_system_pio_input_capture;

  localparam int               WIDTH   = 16;
  localparam logic [WIDTH-1:0] A_MASK0 = 16'h0030;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic [31:0]      rd_a, rd_b, rd_c;
  logic             irq_a, irq_b, irq_c;

  always #5 clk = ~clk;

  nios_system_pio_input_capture #(.WIDTH(WIDTH), .EDGE_TYPE(0), .IRQ_MASK_RESET(A_MASK0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  nios_system_pio_input_capture #(.WIDTH(WIDTH), .EDGE_TYPE(1), .IRQ_MASK_RESET(16'h0000)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  nios_system_pio_input_capture #(.WIDTH(WIDTH), .EDGE_TYPE(2), .IRQ_MASK_RESET(16'h0000)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance past the next rising edge; sampling and driving happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = 16'hFFFF;
    in_b       = 16'h00FF;
    in_c       = 16'h0002;
    repeat (3) tick();

    // In reset: sample regs cleared, mask at its reset value, no irq.
    push("rst_a_data", 32'h0); sel(2'd0); check(rd_a);
    push("rst_a_mask", 32'h0030); sel(2'd2); check(rd_a);
    push("rst_a_irq", 32'h0); check({31'b0, irq_a});

    // Release; the reset-value -> 0xFFFF step must not be captured.
    reset = 1'b0;
    repeat (3) tick();
    push("prime_a_cap", 32'h0); sel(2'd3); check(rd_a);
    push("prime_a_irq", 32'h0); check({31'b0, irq_a});
    push("prime_a_data", 32'h0000FFFF); sel(2'd0); check(rd_a);
    push("prime_b_data", 32'h000000FF); check(rd_b);
    push("prime_c_cap", 32'h0); sel(2'd3); check(rd_c);

    // Rising-edge capture with mask 0x0004.
    in_a = 16'h0000;
    repeat (2) tick();
    push("fall_ignored_a_cap", 32'h0); sel(2'd3); check(rd_a);
    bus_write(2'd2, 32'h0000_0004);
    push("mask_wr_a", 32'h0004); sel(2'd2); check(rd_a);
    in_a = 16'h0005;
    tick();
    push("e0_a_data", 32'h0005); sel(2'd0); check(rd_a);
    push("e0_a_cap", 32'h0); sel(2'd3); check(rd_a);
    push("e0_a_irq", 32'h0); check({31'b0, irq_a});
    tick();
    push("e1_a_cap", 32'h0005); sel(2'd3); check(rd_a);
    push("e1_a_irq", 32'h1); check({31'b0, irq_a});
    bus_write(2'd3, 32'h0000_0004);
    push("clr_a_cap", 32'h0001); sel(2'd3); check(rd_a);
    push("clr_a_irq", 32'h0); check({31'b0, irq_a});

    // Falling capture on B, any-edge capture on C (bit0 rises, bit1 falls).
    in_b = 16'h000F;
    in_c = 16'h0001;
    tick();
    push("fall_b_data", 32'h000F); sel(2'd0); check(rd_b);
    tick();
    push("fall_b_cap", 32'h00F0); sel(2'd3); check(rd_b);
    push("any_c_cap", 32'h0003); check(rd_c);
    in_b = 16'h00FF;
    repeat (2) tick();
    push("rise_ignored_b_cap", 32'h00F0); sel(2'd3); check(rd_b);
    push("masked_b_irq", 32'h0); check({31'b0, irq_b});

    // Bit-3 event on A coincides with a write-1-clear of bit 3: set wins.
    in_a = 16'h000D;
    tick();
    bus_write(2'd3, 32'h0000_0008);
    push("set_wins_a_cap", 32'h0009); sel(2'd3); check(rd_a);
    bus_write(2'd3, 32'h0000_0008);
    push("clr_b3_a_cap", 32'h0001); sel(2'd3); check(rd_a);

    // Writes to DATA and reserved change nothing.
    bus_write(2'd0, 32'hDEAD_BEEF);
    bus_write(2'd1, 32'hDEAD_BEEF);
    push("ro_a_data", 32'h000D); sel(2'd0); check(rd_a);
    push("rsvd_a", 32'h0); sel(2'd1); check(rd_a);
    push("ro_a_mask", 32'h0004); sel(2'd2); check(rd_a);
    push("ro_a_cap", 32'h0001); sel(2'd3); check(rd_a);

    // Mask write with upper bits set reads back zero-extended.
    bus_write(2'd2, 32'hFFFF_FFFF);
    push("wide_a_mask", 32'h0000FFFF); sel(2'd2); check(rd_a);
    push("wide_a_irq", 32'h1); check({31'b0, irq_a});
    push("wide_b_irq", 32'h1); check({31'b0, irq_b});

    // Reset mid-operation drops irq and captures on the sampled edge.
    reset = 1'b1;
    tick();
    push("rst2_a_irq", 32'h0); check({31'b0, irq_a});
    push("rst2_b_irq", 32'h0); check({31'b0, irq_b});
    push("rst2_a_cap", 32'h0); sel(2'd3); check(rd_a);
    push("rst2_a_mask", 32'h0030); sel(2'd2); check(rd_a);
    push("rst2_b_mask", 32'h0000); check(rd_b);
    push("rst2_a_data", 32'h0); sel(2'd0); check(rd_a);
    reset = 1'b0;
    tick();

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nios_system_pio_input_capture
